// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, dispatcher state encoding and the
// transmitter's state values so RX, TX and the TX FIFO agree on them.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } tx_fifo_state_t;

  localparam logic [2:0] TX_S_IDLE      = 3'b000;
  localparam logic [2:0] TX_S_START_BIT = 3'b001;
  localparam logic [2:0] TX_S_DATA_BITS = 3'b010;
  localparam logic [2:0] TX_S_STOP_BIT  = 3'b011;
  localparam logic [2:0] TX_S_CLEANUP   = 3'b100;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// System-side push port and transmitter-side launch handshake of the TX FIFO.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
) ();
  import uart_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  // Push: i_Wr_En is valid, !o_Full is ready; a byte transfers only when both
  // are high at a clock edge, a push while full is dropped and flagged by
  // o_Overflow. Launch: o_TX_DV is a one-cycle pulse with o_TX_Byte stable
  // until the next launch; the transmitter ends the transfer with i_TX_Done.
  logic                   i_Wr_En;
  logic [UART_BYTE_W-1:0] i_Wr_Byte;
  logic                   o_Full;
  logic                   o_Empty;
  logic [ADDR_W:0]        o_Count;
  logic                   o_Overflow;
  logic                   o_Idle;
  logic                   o_TX_DV;
  logic [UART_BYTE_W-1:0] o_TX_Byte;
  logic                   i_TX_Active;
  logic                   i_TX_Done;
  tx_fifo_state_t         o_State;

  modport slave (
    input  i_Wr_En, i_Wr_Byte, i_TX_Active, i_TX_Done,
    output o_Full, o_Empty, o_Count, o_Overflow, o_Idle,
    output o_TX_DV, o_TX_Byte, o_State
  );

  modport master (
    output i_Wr_En, i_Wr_Byte, i_TX_Active, i_TX_Done,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_Idle,
    input  o_TX_DV, o_TX_Byte, o_State
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous circular byte buffer with count-decoded full/empty and a
// registered overflow pulse for pushes dropped while full.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst,
  input  logic                   i_Wr_En,
  input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
  input  logic                   i_Rd_En,
  output logic [UART_BYTE_W-1:0] o_Rd_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Count,
  output logic                   o_Overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] C_FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [UART_BYTE_W-1:0] r_Mem [DEPTH];
  logic [ADDR_W-1:0]      r_Wr_Ptr;
  logic [ADDR_W-1:0]      r_Rd_Ptr;
  logic [ADDR_W:0]        r_Count;
  logic                   r_Overflow;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  assign w_full  = (r_Count == C_FULL_COUNT);
  assign w_empty = (r_Count == '0);
  // Full is judged on the registered count, so a same-cycle pop never frees room.
  assign w_push  = i_Wr_En && !w_full;
  assign w_pop   = i_Rd_En && !w_empty;

  always_ff @(posedge i_Clock) begin
    if (w_push) begin
      r_Mem[r_Wr_Ptr] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_Wr_Ptr   <= '0;
      r_Rd_Ptr   <= '0;
      r_Count    <= '0;
      r_Overflow <= 1'b0;
    end else begin
      r_Overflow <= i_Wr_En && w_full;
      if (w_push) begin
        r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      end
      if (w_pop) begin
        r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_Count <= r_Count + 1'b1;
        2'b01:   r_Count <= r_Count - 1'b1;
        default: r_Count <= r_Count;
      endcase
    end
  end

  assign o_Rd_Byte  = r_Mem[r_Rd_Ptr];
  assign o_Full     = w_full;
  assign o_Empty    = w_empty;
  assign o_Count    = r_Count;
  assign o_Overflow = r_Overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter; a two-state dispatcher launches
// one stored byte at a time and waits for the transmitter's done pulse.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                i_Clock,
  input  logic                i_Rst,
  uart_tx_fifo_if.slave       bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  tx_fifo_state_t         r_State;
  logic                   r_TX_DV;
  logic [UART_BYTE_W-1:0] r_TX_Byte;
  logic                   w_pop;
  logic [UART_BYTE_W-1:0] w_rd_byte;
  logic                   w_full;
  logic                   w_empty;
  logic [ADDR_W:0]        w_count;
  logic                   w_overflow;

  // Launch condition doubles as the FIFO pop; it only looks at registered count.
  assign w_pop = (r_State == S_IDLE) && !w_empty && !bus.i_TX_Active;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_byte_fifo (
    .i_Clock    (i_Clock),
    .i_Rst      (i_Rst),
    .i_Wr_En    (bus.i_Wr_En),
    .i_Wr_Byte  (bus.i_Wr_Byte),
    .i_Rd_En    (w_pop),
    .o_Rd_Byte  (w_rd_byte),
    .o_Full     (w_full),
    .o_Empty    (w_empty),
    .o_Count    (w_count),
    .o_Overflow (w_overflow)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_State   <= S_IDLE;
      r_TX_DV   <= 1'b0;
      r_TX_Byte <= '0;
    end else begin
      case (r_State)
        S_IDLE: begin
          r_TX_DV <= 1'b0;
          if (w_pop) begin
            r_TX_Byte <= w_rd_byte;
            r_TX_DV   <= 1'b1;
            r_State   <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_TX_DV <= 1'b0;
          if (bus.i_TX_Done) begin
            r_State <= S_IDLE;
          end
        end
        default: begin
          r_TX_DV <= 1'b0;
          r_State <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Full     = w_full;
  assign bus.o_Empty    = w_empty;
  assign bus.o_Count    = w_count;
  assign bus.o_Overflow = w_overflow;
  assign bus.o_Idle     = w_empty && (r_State == S_IDLE) && !bus.i_TX_Active;
  assign bus.o_TX_DV    = r_TX_DV;
  assign bus.o_TX_Byte  = r_TX_Byte;
  assign bus.o_State    = r_State;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (DEPTH = 4) with a behavioural transmitter at
// four clocks per bit; launched bytes are checked against an expected queue.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock (clk),
    .i_Rst   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // transmitter model: active/done behave like the real UART TX
  logic       m_busy   = 1'b0;
  logic       m_active = 1'b0;
  logic       m_done   = 1'b0;
  logic       tx_force = 1'b0;
  logic [9:0] m_frame  = '1;
  int         m_tick   = 0;
  bit         ser_q[$];

  assign bus.i_TX_Active = m_active | tx_force;
  assign bus.i_TX_Done   = m_done;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (!m_busy) begin
      if (bus.o_TX_DV) begin
        m_busy   <= 1'b1;
        m_active <= 1'b1;
        m_frame  <= {1'b1, bus.o_TX_Byte, 1'b0};
        m_tick   <= 0;
      end
    end else begin
      if (m_tick % CPB == 0) ser_q.push_back(m_frame[m_tick / CPB]);
      if (m_tick == 10 * CPB - 1) begin
        m_busy   <= 1'b0;
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_tick <= m_tick + 1;
      end
    end
  end

  // scoreboard / monitor
  logic [7:0] exp_q[$];
  int         dv_count  = 0;
  int         gap       = 0;
  bit         gap_valid = 0;
  bit         chk_gap   = 0;
  bit         prev_dv   = 0;

  initial forever begin
    logic [7:0] exp_b;
    @(negedge clk);
    if (bus.i_TX_Done) begin
      gap = 0;
      gap_valid = 1;
    end else begin
      gap++;
    end
    if (bus.o_TX_DV) begin
      dv_count++;
      checks++;
      if (prev_dv) begin
        failures++;
        $display("FAIL dv_width o_TX_DV=1 for 2 cycles, required 1");
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_launch byte=%h required=none", bus.o_TX_Byte);
      end else begin
        exp_b = exp_q.pop_front();
        if (bus.o_TX_Byte !== exp_b) begin
          failures++;
          $display("FAIL launch_byte got=%h required=%h", bus.o_TX_Byte, exp_b);
        end
      end
      if (chk_gap && gap_valid) begin
        checks++;
        if (gap != 2) begin
          failures++;
          $display("FAIL done_to_dv got=%0d cycles required=2", gap);
        end
      end
      gap_valid = 0;
    end
    prev_dv = bus.o_TX_DV;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_accept);
    if (expect_accept) exp_q.push_back(b);
    bus.i_Wr_En   = 1'b1;
    bus.i_Wr_Byte = b;
    @(negedge clk);
    bus.i_Wr_En   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.o_Idle && !m_busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_drain idle=%b pending=%0d required idle=1 pending=0",
               name, bus.o_Idle, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks += 8;
    if (bus.o_TX_DV !== 1'b0)     begin failures++; $display("FAIL rst_dv got=%b required=0", bus.o_TX_DV); end
    if (bus.o_TX_Byte !== 8'h00)  begin failures++; $display("FAIL rst_byte got=%h required=00", bus.o_TX_Byte); end
    if (bus.o_Count !== 3'd0)     begin failures++; $display("FAIL rst_count got=%0d required=0", bus.o_Count); end
    if (bus.o_Empty !== 1'b1)     begin failures++; $display("FAIL rst_empty got=%b required=1", bus.o_Empty); end
    if (bus.o_Full !== 1'b0)      begin failures++; $display("FAIL rst_full got=%b required=0", bus.o_Full); end
    if (bus.o_Overflow !== 1'b0)  begin failures++; $display("FAIL rst_overflow got=%b required=0", bus.o_Overflow); end
    if (bus.o_Idle !== 1'b1)      begin failures++; $display("FAIL rst_idle got=%b required=1", bus.o_Idle); end
    if (bus.o_State !== S_IDLE)   begin failures++; $display("FAIL rst_state got=%b required=%b", bus.o_State, S_IDLE); end
  endtask

  task automatic test_single();
    bit exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    ser_q.delete();
    exp_q.push_back(8'hA5);
    bus.i_Wr_En   = 1'b1;
    bus.i_Wr_Byte = 8'hA5;
    @(negedge clk);
    bus.i_Wr_En = 1'b0;
    checks += 2;
    if (bus.o_TX_DV !== 1'b0) begin failures++; $display("FAIL single_no_early_dv got=%b required=0", bus.o_TX_DV); end
    if (bus.o_Count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d required=1", bus.o_Count); end
    @(negedge clk);
    checks += 2;
    if (bus.o_TX_DV !== 1'b1)    begin failures++; $display("FAIL single_dv got=%b required=1", bus.o_TX_DV); end
    if (bus.o_TX_Byte !== 8'hA5) begin failures++; $display("FAIL single_byte got=%h required=a5", bus.o_TX_Byte); end
    wait_drain("single");
    checks++;
    if (ser_q.size() != 10) begin
      failures++;
      $display("FAIL single_serial_len got=%0d required=10", ser_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (ser_q[i] != exp_bits[i]) begin
          failures++;
          $display("FAIL single_serial_bit%0d got=%b required=%b", i, ser_q[i], exp_bits[i]);
        end
      end
    end
  endtask

  task automatic test_burst();
    int start_dv = dv_count;
    int peak = 0;
    gap_valid = 0;
    chk_gap = 1;
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i), 1'b1);
      if (int'(bus.o_Count) > peak) peak = int'(bus.o_Count);
    end
    wait_drain("burst");
    chk_gap = 0;
    checks += 2;
    if (peak != 4) begin failures++; $display("FAIL burst_peak_count got=%0d required=4", peak); end
    if (dv_count - start_dv != 5) begin failures++; $display("FAIL burst_launches got=%0d required=5", dv_count - start_dv); end
  endtask

  task automatic test_overflow();
    int start_dv = dv_count;
    tx_force = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i), 1'b1);
    checks += 2;
    if (bus.o_Full !== 1'b1)  begin failures++; $display("FAIL ovf_full got=%b required=1", bus.o_Full); end
    if (bus.o_Count !== 3'd4) begin failures++; $display("FAIL ovf_count_full got=%0d required=4", bus.o_Count); end
    push_byte(8'h14, 1'b0);
    checks += 2;
    if (bus.o_Overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b required=1", bus.o_Overflow); end
    if (bus.o_Count !== 3'd4)    begin failures++; $display("FAIL ovf_count_kept got=%0d required=4", bus.o_Count); end
    @(negedge clk);
    checks++;
    if (bus.o_Overflow !== 1'b0) begin failures++; $display("FAIL ovf_pulse_end got=%b required=0", bus.o_Overflow); end
    tx_force = 1'b0;
    wait_drain("overflow");
    checks++;
    if (dv_count - start_dv != 4) begin failures++; $display("FAIL ovf_launches got=%0d required=4", dv_count - start_dv); end
  endtask

  task automatic test_wrap();
    int start_dv = dv_count;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      int waited = 0;
      int gap_n = $urandom_range(0, 3);
      for (int g = 0; g < gap_n; g++) @(negedge clk);
      while (bus.o_Full && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 200) begin
        checks++;
        failures++;
        $display("FAIL wrap_full_stuck waited=%0d required<200", waited);
      end
      push_byte(8'($urandom_range(0, 255)), 1'b1);
    end
    wait_drain("wrap");
    checks++;
    if (dv_count - start_dv != 3 * DEPTH) begin
      failures++;
      $display("FAIL wrap_launches got=%0d required=%0d", dv_count - start_dv, 3 * DEPTH);
    end
  endtask

  task automatic test_simultaneous();
    tx_force = 1'b1;
    push_byte(8'hB1, 1'b1);
    push_byte(8'hB2, 1'b1);
    checks++;
    if (bus.o_Count !== 3'd2) begin failures++; $display("FAIL simul_pre_count got=%0d required=2", bus.o_Count); end
    tx_force = 1'b0;
    push_byte(8'hB3, 1'b1);
    checks += 2;
    if (bus.o_TX_DV !== 1'b1) begin failures++; $display("FAIL simul_dv got=%b required=1", bus.o_TX_DV); end
    if (bus.o_Count !== 3'd2) begin failures++; $display("FAIL simul_count got=%0d required=2", bus.o_Count); end
    wait_drain("simul");
  endtask

  task automatic test_reset_mid();
    int start_dv;
    bit saw_done = 0;
    bit launched = 0;
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i), 1'b1);
    checks++;
    if (bus.o_Count !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d required=3", bus.o_Count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    start_dv = dv_count;
    checks += 4;
    if (bus.o_Count !== 3'd0)   begin failures++; $display("FAIL mid_count got=%0d required=0", bus.o_Count); end
    if (bus.o_TX_DV !== 1'b0)   begin failures++; $display("FAIL mid_dv got=%b required=0", bus.o_TX_DV); end
    if (bus.o_Empty !== 1'b1)   begin failures++; $display("FAIL mid_empty got=%b required=1", bus.o_Empty); end
    if (bus.o_State !== S_IDLE) begin failures++; $display("FAIL mid_state got=%b required=%b", bus.o_State, S_IDLE); end
    push_byte(8'h77, 1'b1);
    for (int i = 0; i < 300 && !launched; i++) begin
      if (bus.i_TX_Done) saw_done = 1;
      if (bus.o_TX_DV) begin
        launched = 1;
        checks++;
        if (!saw_done) begin failures++; $display("FAIL mid_early_launch tx_done_seen=%b required=1", saw_done); end
      end
      @(negedge clk);
    end
    checks++;
    if (!launched) begin failures++; $display("FAIL mid_no_launch launched=0 required=1"); end
    wait_drain("mid");
    checks++;
    if (dv_count - start_dv != 1) begin failures++; $display("FAIL mid_launches got=%0d required=1", dv_count - start_dv); end
  endtask

  initial begin
    bus.i_Wr_En   = 1'b0;
    bus.i_Wr_Byte = 8'h00;
    @(negedge clk);
    test_reset();
    repeat (8) @(negedge clk);
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
